spi_fifo_sequencer: RTL and testbench
=====================================

# spi_fifo_sequencer

SPI master sequencer sitting between a TX FIFO and an RX FIFO (both the team's 32-bit FIFO block) in the SPI controller. Pops 32-bit words from the TX FIFO, shifts each out MSB-first on SPI mode 0 while capturing MISO, and pushes each received word into the RX FIFO. Runs back-to-back words while enabled and data is available, holding chip-select low across the burst.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles; legal range ≥1.
- `WORD_W`, default 32: word width; fixed at 32 for this release.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `enable`  in  1  level; permits starting new words.
- `tx_empty`  in  1  TX FIFO empty flag.
- `tx_rd_en`  out  1  TX FIFO read strobe.
- `tx_data`  in  32  TX FIFO data; valid the cycle after `tx_rd_en`.
- `tx_data_valid`  in  1  TX FIFO output-valid flag.
- `rx_full`  in  1  RX FIFO full flag.
- `rx_wr_en`  out  1  RX FIFO write strobe.
- `rx_data`  out  32  received word.
- `sclk`  out  1  SPI clock; idles low.
- `mosi`  out  1  SPI data out.
- `miso`  in  1  SPI data in.
- `cs_n`  out  1  chip select, active low.
- `busy`  out  1  high whenever state ≠ IDLE.
- `word_count`  out  16  words completed since reset; wraps at 0xFFFF→0.

## Operation
- Reset values: `cs_n`=1, `sclk`=0, `mosi`=0, `tx_rd_en`=0, `rx_wr_en`=0, `rx_data`=0, `busy`=0, `word_count`=0, state IDLE.
- States: IDLE, FETCH, WAIT_DATA, SHIFT, STORE.
- IDLE → FETCH when `enable && !tx_empty && !rx_full`; otherwise stay.
- FETCH: `tx_rd_en`=1 for exactly this cycle; → WAIT_DATA.
- WAIT_DATA: if `tx_data_valid`, load TX shift register with `tx_data`, drive `mosi`=`tx_data[31]`, clear bit/half-period counters → SHIFT; else → IDLE with no transfer and no count change.
- SHIFT: half-period counter 0..CLK_DIV-1; `sclk` toggles when the counter wraps. On the 0→1 edge of `sclk`, shift `miso` into the RX shift register LSB. On the 1→0 edge, shift TX left and drive the next bit on `mosi`. After the 32nd falling edge → STORE; `mosi` holds its last value.
- STORE: `rx_wr_en`=1 for one cycle with `rx_data` = captured word (first bit received at bit 31); `word_count`+1. Then → FETCH if `enable && !tx_empty && !rx_full`, else → IDLE.
- `cs_n` is 0 in FETCH, WAIT_DATA, SHIFT and STORE, and 1 only in IDLE.
- RX overflow is impossible: a word starts only when `!rx_full`, and this block is the sole RX writer.
- `enable` falling mid-word: current word completes through STORE, then IDLE.
- `rst` mid-word: next edge returns all outputs to reset values; partial word discarded, no RX write.
- `tx_rd_en` and `rx_wr_en` are never high in the same cycle.

## Timing
- T = cycle in IDLE with the start condition true. FETCH at T+1 (`tx_rd_en`=1). WAIT_DATA at T+2 (`tx_data_valid`=1). SHIFT begins at T+3 with `sclk`=0 and `mosi`=bit31.
- First `sclk` rise at T+3+CLK_DIV; bit period 2·CLK_DIV cycles; SHIFT lasts 64·CLK_DIV cycles.
- STORE at T+3+64·CLK_DIV. Back-to-back FETCH at T+4+64·CLK_DIV.
- Word-to-word period: 64·CLK_DIV+3 cycles; `cs_n` stays low throughout a burst.
- `mosi` changes only at SHIFT entry or on `sclk` falling edges. It is stable for ≥CLK_DIV cycles before each rising edge.

## Structure
- Package `spi_ctrl_pkg`: state enum (IDLE, FETCH, WAIT_DATA, SHIFT, STORE), `WORD_W`=32, `CNT_W`=16.
- Sub-module `spi_clk_gen`: half-period counter, `sclk` register, one-cycle `rise`/`fall` strobes, enabled only in SHIFT. The FSM and shift registers live in `spi_fifo_sequencer`.

## Test plan
- Reset, `enable`=1, TX empty → IDLE held, `cs_n`=1, no strobes, `word_count`=0.
- CLK_DIV=2, push 0xA5A5_0F0F, MISO loopback → MOSI bits MSB-first match, `rx_wr_en` exactly 131 cycles after T, `rx_data`=0xA5A5_0F0F, `word_count`=1.
- Push 3 words, `enable` held → `cs_n` low continuously, word starts spaced 64·CLK_DIV+3 cycles apart, `word_count`=3, then IDLE.
- `rx_full`=1 with TX non-empty → no FETCH. Release `rx_full` → FETCH on the next IDLE-check cycle.
- `enable` dropped mid-SHIFT → word completes and is stored, then IDLE. `rst` asserted mid-SHIFT → next cycle `cs_n`=1, `sclk`=0, no RX write.
- MISO driven with 0xDEAD_BEEF pattern sampled on rising edges → `rx_data`=0xDEAD_BEEF.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared types and widths for the SPI controller sequencer.
package spi_ctrl_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        WAIT_DATA = 3'd2,
        SHIFT     = 3'd3,
        STORE     = 3'd4
    } state_e;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-period counter, SCLK register and edge strobes.
// Holds SCLK low with a cleared counter whenever not enabled.
module spi_clk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic             wrap_c;

    // Next counter / SCLK value; SCLK toggles when the counter wraps.
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        wrap_c = en_i && (cnt_q == DIV_W'(CLK_DIV - 1));
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (wrap_c) begin
            cnt_d  = '0;
            sclk_d = !sclk_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Counter and SCLK registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;
    assign rise_c = wrap_c && !sclk_q;
    assign fall_c = wrap_c && sclk_q;

endmodule

// File: rtl/spi_fifo_sequencer.sv
// SPI mode-0 master sequencer: TX FIFO -> MOSI, MISO -> RX FIFO, back-to-back words.
module spi_fifo_sequencer
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned WORD_W  = spi_ctrl_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              tx_empty,
    output logic              tx_rd_en,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_data_valid,
    input  logic              rx_full,
    output logic              rx_wr_en,
    output logic [WORD_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n,
    output logic              busy,
    output logic [CNT_W-1:0]  word_count
);

    localparam int unsigned BIT_W = $clog2(WORD_W);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] tx_sr_q, tx_sr_d;
    logic [WORD_W-1:0] rx_sr_q, rx_sr_d;
    logic [WORD_W-1:0] rx_data_q, rx_data_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              mosi_q, mosi_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;
    logic              tx_rd_en_q, rx_wr_en_q, cs_n_q, busy_q;
    logic              start_c, rise_c, fall_c;

    // SCLK only runs while shifting.
    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == SHIFT),
        .sclk_o (sclk),
        .rise_c (rise_c),
        .fall_c (fall_c)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d      = state_q;
        tx_sr_d      = tx_sr_q;
        rx_sr_d      = rx_sr_q;
        rx_data_d    = rx_data_q;
        bit_cnt_d    = bit_cnt_q;
        mosi_d       = mosi_q;
        word_count_d = word_count_q;
        start_c      = enable && !tx_empty && !rx_full;
        case (state_q)
            IDLE: begin
                if (start_c) state_d = FETCH;
            end
            FETCH: begin
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (tx_data_valid) begin
                    tx_sr_d   = tx_data;
                    mosi_d    = tx_data[WORD_W-1];
                    rx_sr_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (rise_c) rx_sr_d = {rx_sr_q[WORD_W-2:0], miso};
                if (fall_c) begin
                    if (bit_cnt_q == BIT_W'(WORD_W - 1)) begin
                        // Last falling edge: MOSI keeps its final bit.
                        rx_data_d    = rx_sr_q;
                        word_count_d = word_count_q + CNT_W'(1);
                        state_d      = STORE;
                    end else begin
                        tx_sr_d   = {tx_sr_q[WORD_W-2:0], 1'b0};
                        mosi_d    = tx_sr_q[WORD_W-2];
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            STORE: begin
                state_d = start_c ? FETCH : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            rx_data_q    <= '0;
            bit_cnt_q    <= '0;
            mosi_q       <= 1'b0;
            word_count_q <= '0;
            tx_rd_en_q   <= 1'b0;
            rx_wr_en_q   <= 1'b0;
            cs_n_q       <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_sr_q      <= tx_sr_d;
            rx_sr_q      <= rx_sr_d;
            rx_data_q    <= rx_data_d;
            bit_cnt_q    <= bit_cnt_d;
            mosi_q       <= mosi_d;
            word_count_q <= word_count_d;
            tx_rd_en_q   <= (state_d == FETCH);
            rx_wr_en_q   <= (state_d == STORE);
            cs_n_q       <= (state_d == IDLE);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign tx_rd_en   = tx_rd_en_q;
    assign rx_wr_en   = rx_wr_en_q;
    assign rx_data    = rx_data_q;
    assign mosi       = mosi_q;
    assign cs_n       = cs_n_q;
    assign busy       = busy_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_spi_fifo_sequencer.sv
// Scoreboard bench for spi_fifo_sequencer (CLK_DIV=2, TX FIFO model, MISO loopback/pattern).
module tb_spi_fifo_sequencer;

    localparam int unsigned CLK_DIV = 2;
    localparam int          WORD_PERIOD = 64 * CLK_DIV + 3;

    typedef struct {
        logic [31:0] tx;
        logic [31:0] rx;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        tx_empty;
    logic        tx_rd_en;
    logic [31:0] tx_data = '0;
    logic        tx_data_valid = 1'b0;
    logic        rx_full;
    logic        rx_wr_en;
    logic [31:0] rx_data;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        cs_n;
    logic        busy;
    logic [15:0] word_count;

    logic [31:0] tx_mem [0:15];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    logic        pat_mode;
    logic [31:0] pat_word;
    logic [4:0]  pat_bit = 5'd31;
    logic [31:0] mosi_cap = '0;
    logic        sclk_prev = 1'b0;

    exp_t        sb_q[$];
    logic [15:0] exp_cnt = '0;
    int          checks = 0;
    int          failures = 0;

    spi_fifo_sequencer #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .tx_empty      (tx_empty),
        .tx_rd_en      (tx_rd_en),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .rx_full       (rx_full),
        .rx_wr_en      (rx_wr_en),
        .rx_data       (rx_data),
        .sclk          (sclk),
        .mosi          (mosi),
        .miso          (miso),
        .cs_n          (cs_n),
        .busy          (busy),
        .word_count    (word_count)
    );

    always #5 clk = ~clk;

    assign tx_empty = (wr_ptr == rd_ptr);
    assign miso     = pat_mode ? pat_word[pat_bit] : mosi;

    // TX FIFO model: data and valid appear the cycle after the read strobe.
    always @(posedge clk) begin
        if (tx_rd_en && (rd_ptr != wr_ptr)) begin
            tx_data       <= tx_mem[rd_ptr];
            tx_data_valid <= 1'b1;
            rd_ptr        <= rd_ptr + 1;
        end else begin
            tx_data_valid <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input bit expect_it, input logic [31:0] exp_rx);
        tx_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
        if (expect_it) begin
            exp_cnt = exp_cnt + 16'd1;
            sb_q.push_back('{tx: w, rx: exp_rx, cnt: exp_cnt});
        end
    endtask

    task automatic wait_rx_idle(input string name, input int n);
        int seen = 0;
        bit done = 0;
        for (int k = 0; k < 1500 && !done; k++) begin
            @(negedge clk);
            if (rx_wr_en) seen++;
            if (seen >= n && !busy) done = 1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    // Monitor: tracks SCLK edges, drives the MISO pattern index, pops the scoreboard on RX writes.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (sclk && !sclk_prev) begin
                mosi_cap = {mosi_cap[30:0], mosi};
                pat_bit  = pat_bit - 5'd1;
            end
            sclk_prev = sclk;
            if (cs_n || rx_wr_en) pat_bit = 5'd31;
            check("cs_n_vs_busy", 32'(cs_n), 32'(!busy));
            check("rd_wr_overlap", 32'(tx_rd_en && rx_wr_en), 32'd0);
            if (rx_wr_en) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rx_write", rx_data, 32'hxxxx_xxxx);
                end else begin
                    e = sb_q.pop_front();
                    check("rx_data", rx_data, e.rx);
                    check("word_count_at_store", 32'(word_count), 32'(e.cnt));
                    check("mosi_bits", mosi_cap, e.tx);
                end
            end
        end
    endtask

    task automatic run_tests();
        int rd_at, rx_at, nrx, rd_cnt;
        int rx_t [3];
        bit cs_gap, rd_seen, found;

        // Reset with enable high and TX empty: stays idle.
        rst = 1'b1; enable = 1'b1; rx_full = 1'b0; pat_mode = 1'b0; pat_word = '0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_rx_data", rx_data, 32'd0);
        rst = 1'b0;
        rd_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tx_rd_en || rx_wr_en) rd_cnt++;
        end
        check("idle_no_strobes", 32'(rd_cnt), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_word_count", 32'(word_count), 32'd0);

        // Single word, loopback, latency and first-edge timing.
        push_word(32'hA5A5_0F0F, 1'b1, 32'hA5A5_0F0F);
        rd_at = -1; rx_at = -1;
        for (int k = 1; k <= 400 && rx_at < 0; k++) begin
            @(negedge clk);
            if (tx_rd_en && rd_at < 0) rd_at = k;
            if (k == 3) begin
                check("shift_entry_mosi", 32'(mosi), 32'd1);
                check("shift_entry_sclk", 32'(sclk), 32'd0);
            end
            if (k == 2 + CLK_DIV) check("pre_rise_sclk", 32'(sclk), 32'd0);
            if (k == 3 + CLK_DIV) check("first_rise_sclk", 32'(sclk), 32'd1);
            if (rx_wr_en) rx_at = k;
        end
        check("fetch_latency", 32'(rd_at), 32'd1);
        check("store_latency", 32'(rx_at), 32'd131);
        wait_rx_idle("single_idle", 0);
        check("single_word_count", 32'(word_count), 32'd1);

        // Three-word burst: constant word period, CS held low.
        push_word(32'h0000_0001, 1'b1, 32'h0000_0001);
        push_word(32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF);
        push_word(32'h8000_0000, 1'b1, 32'h8000_0000);
        nrx = 0; cs_gap = 0; rd_seen = 0;
        for (int k = 1; k <= 800 && nrx < 3; k++) begin
            @(negedge clk);
            if (tx_rd_en) rd_seen = 1;
            if (rd_seen && cs_n) cs_gap = 1;
            if (rx_wr_en) begin
                rx_t[nrx] = k;
                nrx++;
            end
        end
        check("burst_words", 32'(nrx), 32'd3);
        check("burst_first", 32'(rx_t[0]), 32'd131);
        check("burst_gap1", 32'(rx_t[1] - rx_t[0]), 32'(WORD_PERIOD));
        check("burst_gap2", 32'(rx_t[2] - rx_t[1]), 32'(WORD_PERIOD));
        check("burst_cs_low", 32'(cs_gap), 32'd0);
        @(negedge clk);
        check("burst_end_cs_n", 32'(cs_n), 32'd1);
        check("burst_word_count", 32'(word_count), 32'd4);

        // RX full blocks the fetch; release starts on the next IDLE check.
        rx_full = 1'b1;
        push_word(32'h3C3C_C3C3, 1'b1, 32'h3C3C_C3C3);
        rd_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (tx_rd_en) rd_cnt++;
        end
        check("rx_full_no_fetch", 32'(rd_cnt), 32'd0);
        check("rx_full_cs_n", 32'(cs_n), 32'd1);
        rx_full = 1'b0;
        rd_at = -1;
        for (int k = 1; k <= 10 && rd_at < 0; k++) begin
            @(negedge clk);
            if (tx_rd_en) rd_at = k;
        end
        check("rx_release_fetch", 32'(rd_at), 32'd1);
        wait_rx_idle("rx_full_idle", 1);

        // Enable dropped mid-SHIFT: current word completes, next waits.
        push_word(32'h0F0F_F0F0, 1'b1, 32'h0F0F_F0F0);
        push_word(32'h1357_9BDF, 1'b1, 32'h1357_9BDF);
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (sclk) found = 1;
        end
        check("en_drop_reached_shift", 32'(found), 32'd1);
        enable = 1'b0;
        nrx = 0; found = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (rx_wr_en) nrx++;
            if (!busy) found = 1;
        end
        check("en_drop_one_word", 32'(nrx), 32'd1);
        rd_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tx_rd_en) rd_cnt++;
        end
        check("en_drop_no_fetch", 32'(rd_cnt), 32'd0);
        check("en_drop_word_count", 32'(word_count), 32'd6);
        enable = 1'b1;
        wait_rx_idle("en_resume_idle", 1);
        check("en_resume_word_count", 32'(word_count), 32'd7);

        // Reset mid-SHIFT: partial word discarded.
        push_word(32'hCAFE_F00D, 1'b0, 32'h0);
        repeat (20) @(negedge clk);
        enable = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        exp_cnt = '0;
        check("midrst_cs_n", 32'(cs_n), 32'd1);
        check("midrst_sclk", 32'(sclk), 32'd0);
        check("midrst_rx_wr_en", 32'(rx_wr_en), 32'd0);
        check("midrst_word_count", 32'(word_count), 32'd0);
        check("midrst_mosi", 32'(mosi), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (150) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        // MISO driven with a fixed pattern independent of MOSI.
        pat_mode = 1'b1;
        pat_word = 32'hDEAD_BEEF;
        enable = 1'b1;
        push_word(32'h1234_5678, 1'b1, 32'hDEAD_BEEF);
        wait_rx_idle("pattern_idle", 1);
        check("pattern_word_count", 32'(word_count), 32'd1);
        check("pattern_rx_data_held", rx_data, 32'hDEAD_BEEF);
        pat_mode = 1'b0;

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; rx_full = 1'b0; pat_mode = 1'b0; pat_word = '0;
        fork
            monitor();
            run_tests();
            begin
                repeat (20000) @(posedge clk);
                failures++;
                $display("FAIL watchdog: got timeout expected completion");
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
